// File: rtl/float_point_accumulator_if.sv
// Stream bundle for the FP accumulator: operand input side and result output side.
interface float_point_accumulator_if #(
    parameter int unsigned EXP_LEN      = 8,
    parameter int unsigned MANTISSA_LEN = 23,
    parameter int unsigned COUNT_W      = 16
);
    logic                              in_valid;
    logic                              in_ready;
    logic [EXP_LEN+MANTISSA_LEN:0]     in_data;
    logic                              in_last;
    logic                              out_valid;
    logic                              out_ready;
    logic [EXP_LEN+MANTISSA_LEN:0]     out_data;
    logic [COUNT_W-1:0]                out_count;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    // The accumulator itself
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/float_point_accumulator.sv
// Sums a framed stream of FP values into one FP result using a single shared
// adder walked through ALIGN/ADD/NORM. Truncating arithmetic, flush-to-zero,
// saturation to {sign, all-ones, 0} on exponent overflow.
module float_point_accumulator #(
    parameter int unsigned EXP_LEN      = 8,
    parameter int unsigned MANTISSA_LEN = 23,
    parameter int unsigned COUNT_W      = 16
) (
    input logic                    clk,
    input logic                    rst,
    float_point_accumulator_if.slave bus
);
    localparam int unsigned W   = EXP_LEN + MANTISSA_LEN + 1;
    localparam int unsigned MW  = MANTISSA_LEN + 1;          // mantissa with hidden bit
    localparam int unsigned SW  = MANTISSA_LEN + 2;          // adder width with carry
    localparam int unsigned LZW = $clog2(MW + 1);
    localparam logic [EXP_LEN:0] EXP_SAT = {1'b0, {EXP_LEN{1'b1}}};

    typedef enum logic [2:0] {
        S_ACCEPT,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_OUTPUT
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         acc_q, acc_d;
    logic [W-1:0]         op_q, op_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 last_q, last_d;
    logic                 big_sign_q, big_sign_d;
    logic                 eff_sub_q, eff_sub_d;
    logic [EXP_LEN-1:0]   big_exp_q, big_exp_d;
    logic [MW-1:0]        big_mag_q, big_mag_d;
    logic [MW-1:0]        small_mag_q, small_mag_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [W-1:0]         out_data_q, out_data_d;
    logic [COUNT_W-1:0]   out_count_q, out_count_d;

    logic                 in_ready, out_valid;

    // Alignment signals
    logic                 a_sign, b_sign, a_zero, b_zero, a_ge_b;
    logic [EXP_LEN-1:0]   a_exp, b_exp, diff, small_exp;
    logic [MW-1:0]        a_mag, b_mag, small_mag;
    logic [MW-1:0]        small_sh;

    // Normalisation signals
    logic [LZW-1:0]       lz;
    logic                 lz_found;
    logic [SW-1:0]        sum_shl;
    logic [EXP_LEN:0]     exp_up;
    logic [EXP_LEN-1:0]   exp_dn;
    logic [W-1:0]         norm_res;
    logic [SW-1:0]        sum_calc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_ACCEPT;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_ACCEPT: begin
                in_ready = !rst;
                if (bus.in_valid) state_d = S_ALIGN;
            end
            S_ALIGN:  state_d = S_ADD;
            S_ADD:    state_d = S_NORM;
            S_NORM:   state_d = last_q ? S_OUTPUT : S_ACCEPT;
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = S_ACCEPT;
            end
            default:  state_d = S_ACCEPT;
        endcase
    end

    // Order accumulator and operand by magnitude and align the smaller one;
    // a zero operand gets magnitude 0 so it always loses and contributes nothing
    always_comb begin
        a_sign = acc_q[W-1];
        b_sign = op_q[W-1];
        a_exp  = acc_q[W-2 -: EXP_LEN];
        b_exp  = op_q[W-2 -: EXP_LEN];
        a_zero = (acc_q[W-2:0] == '0);
        b_zero = (op_q[W-2:0] == '0);
        a_mag  = a_zero ? '0 : {1'b1, acc_q[MANTISSA_LEN-1:0]};
        b_mag  = b_zero ? '0 : {1'b1, op_q[MANTISSA_LEN-1:0]};
        a_ge_b = (acc_q[W-2:0] >= op_q[W-2:0]);
        if (a_ge_b) begin
            big_sign_d  = a_sign;
            big_exp_d   = a_exp;
            big_mag_d   = a_mag;
            small_exp   = b_exp;
            small_mag   = b_mag;
        end else begin
            big_sign_d  = b_sign;
            big_exp_d   = b_exp;
            big_mag_d   = b_mag;
            small_exp   = a_exp;
            small_mag   = a_mag;
        end
        eff_sub_d = (a_sign != b_sign);
        diff      = big_exp_d - small_exp;
        if (32'(diff) >= SW) small_sh = '0;
        else                 small_sh = small_mag >> diff;
        small_mag_d = small_sh;
    end

    // Signed-magnitude add of the aligned mantissas
    always_comb begin
        if (eff_sub_q) sum_calc = {1'b0, big_mag_q} - {1'b0, small_mag_q};
        else           sum_calc = {1'b0, big_mag_q} + {1'b0, small_mag_q};
    end

    // Renormalise the raw sum, with flush-to-zero and exponent saturation
    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int unsigned i = 0; i < MW; i++) begin
            if (!lz_found && sum_q[MANTISSA_LEN - i]) begin
                lz       = LZW'(i);
                lz_found = 1'b1;
            end
        end
        sum_shl  = sum_q << lz;
        exp_up   = {1'b0, big_exp_q} + 1'b1;
        exp_dn   = big_exp_q - EXP_LEN'(lz);
        norm_res = '0;
        if (sum_q[SW-1]) begin
            if (exp_up >= EXP_SAT)
                norm_res = {big_sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
            else
                norm_res = {big_sign_q, exp_up[EXP_LEN-1:0], sum_q[MANTISSA_LEN:1]};
        end else if (sum_q == '0) begin
            norm_res = '0;
        end else if ({1'b0, big_exp_q} < ((EXP_LEN+1)'(lz) + 1'b1)) begin
            norm_res = '0;
        end else if ({1'b0, exp_dn} >= EXP_SAT) begin
            norm_res = {big_sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
        end else begin
            norm_res = {big_sign_q, exp_dn, sum_shl[MANTISSA_LEN-1:0]};
        end
    end

    // Datapath next-state, selected by the current FSM phase
    always_comb begin
        acc_d       = acc_q;
        op_d        = op_q;
        count_d     = count_q;
        last_d      = last_q;
        sum_d       = sum_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        case (state_q)
            S_ACCEPT: begin
                if (bus.in_valid) begin
                    op_d    = bus.in_data;
                    last_d  = bus.in_last;
                    count_d = count_q + 1'b1;
                end
            end
            S_ADD:    sum_d = sum_calc;
            S_NORM: begin
                acc_d = norm_res;
                if (last_q) begin
                    out_data_d  = norm_res;
                    out_count_d = count_q;
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    last_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; alignment registers only load in ALIGN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            op_q        <= '0;
            count_q     <= '0;
            last_q      <= 1'b0;
            big_sign_q  <= 1'b0;
            eff_sub_q   <= 1'b0;
            big_exp_q   <= '0;
            big_mag_q   <= '0;
            small_mag_q <= '0;
            sum_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            acc_q       <= acc_d;
            op_q        <= op_d;
            count_q     <= count_d;
            last_q      <= last_d;
            sum_q       <= sum_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            if (state_q == S_ALIGN) begin
                big_sign_q  <= big_sign_d;
                eff_sub_q   <= eff_sub_d;
                big_exp_q   <= big_exp_d;
                big_mag_q   <= big_mag_d;
                small_mag_q <= small_mag_d;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

endmodule
